// File: rtl/uart_pkg.sv
// uart_pkg: constants and receiver state type shared across the UART link
package uart_pkg;
    localparam logic [7:0] ACK_BYTE = 8'hCC;
    localparam int unsigned CLKS_PER_BIT_DEF = 2604;
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, ACK_GAP, ACK_START, ACK_DATA, ACK_STOP
    } rx_state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: half- and full-bit ticks; held at zero while restart is high,
// and reloads itself on every full tick so consecutive bits stay aligned.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic half_tick,
    output logic full_tick
);
    localparam int unsigned TW = $clog2(CLKS_PER_BIT + 1);
    logic [TW-1:0] cnt_q;
    assign half_tick = cnt_q == TW'(CLKS_PER_BIT / 2 - 1);
    assign full_tick = cnt_q == TW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk)
        cnt_q <= (reset || restart || full_tick) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_rx_ack.sv
// uart_rx_ack: 8N1 MSB-first receiver with one-entry output buffer that
// answers every accepted frame with an ACK_BYTE frame on ack_out.
module uart_rx_ack
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned ACK_GAP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic       ack_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int unsigned GW = ACK_GAP_BITS > 1 ? $clog2(ACK_GAP_BITS) : 1;
    rx_state_t     state_q;
    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic [7:0]    shreg_q;
    logic [2:0]    bit_idx_q;
    logic [GW-1:0] gap_q;
    logic          ack_q;
    logic          valid_q;
    logic [7:0]    data_q;
    logic          ferr_q;
    logic          ovr_q;
    logic          busy_q;
    logic          rx_s;
    logic          accept;
    logic          restart;
    logic          half_tick;
    logic          full_tick;
    assign rx_s    = sync_q[1];
    assign accept  = valid_q && rx_ready;
    // only IDLE and the half-bit START decision leave off-grid; all other exits ride the full-tick reload
    assign restart = state_q == IDLE || (state_q == START && half_tick);
    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk(clk),
        .reset(reset),
        .restart(restart),
        .half_tick(half_tick),
        .full_tick(full_tick)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            gap_q     <= '0;
            ack_q     <= 1'b1;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx_in};
            rx_prev_q <= rx_s;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            if (accept) valid_q <= 1'b0;
            case (state_q)
                IDLE: if (rx_prev_q && !rx_s) begin
                    state_q <= START;
                    busy_q  <= 1'b1;
                end
                START: if (half_tick) begin
                    state_q   <= rx_s ? IDLE : DATA;
                    busy_q    <= !rx_s;
                    bit_idx_q <= '0;
                end
                DATA: if (full_tick) begin
                    shreg_q   <= {shreg_q[6:0], rx_s};
                    bit_idx_q <= bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_q <= STOP;
                end
                STOP: if (full_tick) begin
                    if (!rx_s) begin
                        ferr_q  <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (valid_q && !rx_ready) begin
                        ovr_q   <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        data_q  <= shreg_q;
                        valid_q <= 1'b1;
                        gap_q   <= '0;
                        state_q <= ACK_GAP;
                    end
                end
                ACK_GAP: if (full_tick) begin
                    gap_q <= gap_q + 1'b1;
                    if (gap_q == GW'(ACK_GAP_BITS - 1)) begin
                        state_q <= ACK_START;
                        ack_q   <= 1'b0;
                    end
                end
                ACK_START: if (full_tick) begin
                    state_q   <= ACK_DATA;
                    ack_q     <= ACK_BYTE[7];
                    bit_idx_q <= '0;
                end
                ACK_DATA: if (full_tick) begin
                    bit_idx_q <= bit_idx_q + 3'd1;
                    ack_q     <= bit_idx_q == 3'd7 ? 1'b1 : ACK_BYTE[3'd6 - bit_idx_q];
                    if (bit_idx_q == 3'd7) state_q <= ACK_STOP;
                end
                ACK_STOP: if (full_tick) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ack_out   = ack_q;
    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_uart_rx_ack.sv
// tb_uart_rx_ack: randomized and directed frames against a queue-based
// scoreboard of delivered bytes, ack frames and error pulse counts.
module tb_uart_rx_ack;
    localparam int CPB = 16;
    localparam logic [7:0] ACK_EXP = 8'hCC;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic       ack_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_load = 0;
    int ferr_seen = 0;
    int ovr_seen = 0;
    int exp_ferr = 0;
    int exp_ovr = 0;
    logic [7:0] exp_data[$];
    logic [7:0] exp_ack[$];
    bit         pv = 1'b0;
    logic [7:0] pd = '0;
    bit         ack_act = 1'b0;
    int         ack_cnt = 0;
    logic [7:0] ack_sh = '0;

    uart_rx_ack #(.CLKS_PER_BIT(CPB), .ACK_GAP_BITS(1)) dut (
        .clk(clk),
        .reset(reset),
        .rx_in(rx_in),
        .ack_out(ack_out),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        tick();
        rx_in = 1'b0;
        repeat (CPB) tick();
        for (int i = 7; i >= 0; i--) begin
            rx_in = b[i];
            repeat (CPB) tick();
        end
        rx_in = stop;
        repeat (CPB) tick();
        rx_in = 1'b1;
    endtask

    // expected outcome of one frame, decided from the frame and buffer rules alone
    task automatic send_expect(input logic [7:0] b, input logic stop, input bit buf_full);
        if (!stop) exp_ferr++;
        else if (buf_full) exp_ovr++;
        else begin
            exp_data.push_back(b);
            exp_ack.push_back(ACK_EXP);
        end
        send_byte(b, stop);
        repeat (200) tick();
    endtask

    // monitor: consumes bytes, decodes ack frames, counts pulses
    always @(negedge clk) begin
        if (reset) begin
            ack_act = 1'b0;
            pv = 1'b0;
        end else begin
            if (frame_err) ferr_seen++;
            if (overrun) ovr_seen++;
            if (rx_valid && (!pv || rx_data != pd)) last_load = cyc;
            pv = rx_valid;
            pd = rx_data;
            if (rx_valid && rx_ready) begin
                if (exp_data.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rx_data: got unexpected byte %0h expected none", rx_data);
                end else check("rx_data", rx_data, exp_data.pop_front());
            end
            if (!ack_act) begin
                if (!ack_out) begin
                    ack_act = 1'b1;
                    ack_cnt = 0;
                    ack_sh = '0;
                    check("ack_start_delay", cyc - last_load, CPB);
                end
            end else begin
                ack_cnt++;
                if (ack_cnt % CPB == CPB / 2) begin
                    if (ack_cnt / CPB >= 1 && ack_cnt / CPB <= 8) ack_sh = {ack_sh[6:0], ack_out};
                    else if (ack_cnt / CPB == 9) begin
                        ack_act = 1'b0;
                        check("ack_stop", ack_out, 1);
                        if (exp_ack.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL ack: got unexpected ack %0h expected none", ack_sh);
                        end else check("ack_byte", ack_sh, exp_ack.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_ack_out", ack_out, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        // good frame
        rx_ready = 1'b1;
        send_expect(8'hA5, 1'b1, 1'b0);
        check("good_valid_clear", rx_valid, 0);
        // bad stop bit
        send_expect(8'h3C, 1'b0, 1'b0);
        check("ferr_count", ferr_seen, exp_ferr);
        check("ferr_no_valid", rx_valid, 0);
        check("ferr_idle", busy, 0);
        // glitch
        tick();
        rx_in = 1'b0;
        repeat (5) tick();
        rx_in = 1'b1;
        repeat (15) tick();
        @(negedge clk);
        check("glitch_busy", busy, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_ack", ack_out, 1);
        check("glitch_ferr", ferr_seen, exp_ferr);
        // randomized frames with a ready consumer
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            send_expect(b, $urandom_range(0, 3) != 0, 1'b0);
        end
        check("rand_ferr_count", ferr_seen, exp_ferr);
        check("rand_ovr_count", ovr_seen, exp_ovr);
        // overrun
        rx_ready = 1'b0;
        send_expect(8'h11, 1'b1, 1'b0);
        send_expect(8'h22, 1'b1, 1'b1);
        check("ovr_count", ovr_seen, exp_ovr);
        check("ovr_valid_held", rx_valid, 1);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        check("ovr_valid_drop", rx_valid, 0);
        // accept and load in the same cycle
        send_expect(8'h11, 1'b1, 1'b0);
        exp_data.push_back(8'h22);
        exp_ack.push_back(ACK_EXP);
        fork
            send_byte(8'h22, 1'b1);
            begin
                repeat (155) tick();
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
            end
        join
        repeat (200) tick();
        check("simul_valid_kept", rx_valid, 1);
        check("simul_no_ovr", ovr_seen, exp_ovr);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
        check("simul_valid_drop", rx_valid, 0);
        // reset mid-ack with a byte still buffered
        send_byte(8'($urandom), 1'b1);
        repeat (40) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_ack_out", ack_out, 1);
        check("rst_mid_valid", rx_valid, 0);
        check("rst_mid_busy", busy, 0);
        rx_ready = 1'b1;
        send_expect(8'h5A, 1'b1, 1'b0);
        check("final_data_queue", exp_data.size(), 0);
        check("final_ack_queue", exp_ack.size(), 0);
        check("final_ferr", ferr_seen, exp_ferr);
        check("final_ovr", ovr_seen, exp_ovr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
